// File: rtl/shake_pad_loader.sv
// shake_pad_loader: packs a little-endian 64-bit word stream into 1088-bit
// SHAKE rate blocks, applying the 0x1F ... 0x80 domain/pad bytes on the final
// block. A message whose length is an exact multiple of the rate gets a
// trailing pad-only block.
module shake_pad_loader #(
  parameter int RATE_WORDS = 17
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [63:0]              in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [3:0]               in_bytes,
  output logic                     in_ready,
  output logic [RATE_WORDS*64-1:0] blk_data,
  output logic [10:0]              blk_length,
  output logic                     blk_last,
  output logic                     blk_valid,
  input  logic                     blk_ready
);

  localparam int         BLK_BITS  = RATE_WORDS * 64;
  localparam logic [4:0] LAST_WORD = 5'(RATE_WORDS - 1);
  localparam logic [7:0] LAST_BYTE = 8'(RATE_WORDS * 8 - 1);

  // S_INIT is the post-reset "fill pending" state so in_ready stays low
  // until the first clock edge after reset is released.
  typedef enum logic [1:0] {S_INIT, S_FILL, S_EXTRA, S_EMIT} state_t;

  state_t              state_reg, state_next;
  logic [BLK_BITS-1:0] buf_reg, buf_next;
  logic [4:0]          wcnt_reg, wcnt_next;
  logic [10:0]         len_reg, len_next;
  logic                last_reg, last_next;
  logic                extra_reg, extra_next;

  logic                accept;
  logic [3:0]          nbytes;
  logic [63:0]         word_mask;
  logic [7:0]          pad_pos;
  logic [10:0]         word_base;
  logic [10:0]         pad_base;

  assign accept    = (state_reg == S_FILL) && in_valid;
  assign nbytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
  assign pad_pos   = {wcnt_reg, 3'b000} + {4'b0000, nbytes};
  assign word_base = {wcnt_reg, 6'b000000};
  assign pad_base  = {pad_pos, 3'b000};

  // Keep only the valid low-order bytes of the final word.
  for (genvar gi = 0; gi < 8; gi++) begin : g_mask
    assign word_mask[8*gi +: 8] = (4'(gi) < nbytes) ? 8'hFF : 8'h00;
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_reg <= S_INIT;
    else        state_reg <= state_next;
  end

  // Next-state logic: any last word or a word filling slot 16 closes a block.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:  state_next = S_FILL;
      S_FILL:  if (accept && (in_last || wcnt_reg == LAST_WORD)) state_next = S_EMIT;
      S_EXTRA: state_next = S_EMIT;
      S_EMIT:  if (blk_ready) state_next = extra_reg ? S_EXTRA : S_FILL;
      default: state_next = S_INIT;
    endcase
  end

  // Output logic: handshakes are pure functions of the state.
  always_comb begin
    in_ready  = (state_reg == S_FILL);
    blk_valid = (state_reg == S_EMIT);
  end

  // Datapath next values: word stores, padding, pad-only block, clear on emit.
  always_comb begin
    buf_next   = buf_reg;
    wcnt_next  = wcnt_reg;
    len_next   = len_reg;
    last_next  = last_reg;
    extra_next = extra_reg;
    case (state_reg)
      S_FILL: begin
        if (accept && !in_last) begin
          buf_next[word_base +: 64] = in_data;
          if (wcnt_reg == LAST_WORD) begin
            len_next  = 11'(BLK_BITS);
            last_next = 1'b0;
          end else begin
            wcnt_next = wcnt_reg + 5'd1;
          end
        end else if (accept) begin
          buf_next[word_base +: 64] = in_data & word_mask;
          if (pad_pos <= LAST_BYTE) begin
            // When pad_pos is the last byte both ORs hit it, giving 0x9F.
            buf_next[pad_base +: 8]     = buf_next[pad_base +: 8] | 8'h1F;
            buf_next[BLK_BITS-1 -: 8]   = buf_next[BLK_BITS-1 -: 8] | 8'h80;
            len_next                    = pad_base;
            last_next                   = 1'b1;
          end else begin
            // Message filled the rate exactly: padding goes in its own block.
            len_next   = 11'(BLK_BITS);
            last_next  = 1'b0;
            extra_next = 1'b1;
          end
        end
      end
      S_EXTRA: begin
        buf_next                  = '0;
        buf_next[7:0]             = 8'h1F;
        buf_next[BLK_BITS-1 -: 8] = 8'h80;
        len_next                  = 11'd0;
        last_next                 = 1'b1;
        extra_next                = 1'b0;
      end
      S_EMIT: begin
        if (blk_ready) begin
          buf_next  = '0;
          wcnt_next = 5'd0;
          len_next  = 11'd0;
          last_next = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset discards any partial message.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      buf_reg   <= '0;
      wcnt_reg  <= 5'd0;
      len_reg   <= 11'd0;
      last_reg  <= 1'b0;
      extra_reg <= 1'b0;
    end else begin
      buf_reg   <= buf_next;
      wcnt_reg  <= wcnt_next;
      len_reg   <= len_next;
      last_reg  <= last_next;
      extra_reg <= extra_next;
    end
  end

  assign blk_data   = buf_reg;
  assign blk_length = len_reg;
  assign blk_last   = last_reg;

endmodule

// File: tb/tb_shake_pad_loader.sv
// Directed bench for shake_pad_loader: hand-computed padded blocks for empty,
// short, 135/136-byte, back-pressure and reset-abort messages.
module tb_shake_pad_loader;

  logic          clock;
  logic          reset;
  logic [63:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic [3:0]    in_bytes;
  logic          in_ready;
  logic [1087:0] blk_data;
  logic [10:0]   blk_length;
  logic          blk_last;
  logic          blk_valid;
  logic          blk_ready;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [1087:0] exp_blk;
  logic [63:0]   w;

  shake_pad_loader #(.RATE_WORDS(17)) dut (
    .clock      (clock),
    .reset      (reset),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_bytes   (in_bytes),
    .in_ready   (in_ready),
    .blk_data   (blk_data),
    .blk_length (blk_length),
    .blk_last   (blk_last),
    .blk_valid  (blk_valid),
    .blk_ready  (blk_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one word at a negedge and hold it through the accepting posedge.
  task automatic send_word(input logic [63:0] d, input logic last, input logic [3:0] nb);
    int n;
    @(negedge clock);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    in_bytes = nb;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    in_bytes = '0;
  endtask

  // Wait for a block (expected after exp_wait idle negedges), check it, consume it.
  task automatic recv_block(input string tag, input logic [1087:0] exp_data,
                            input logic [10:0] exp_len, input logic exp_last, input int exp_wait);
    int n;
    n = 0;
    @(negedge clock);
    while (!blk_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(exp_wait));
    check({tag, "_valid"}, 64'(blk_valid), 64'd1);
    check({tag, "_len"}, 64'(blk_length), 64'(exp_len));
    check({tag, "_last"}, 64'(blk_last), 64'(exp_last));
    for (int k = 0; k < 17; k++)
      check($sformatf("%s_w%0d", tag, k), blk_data[64*k +: 64], exp_data[64*k +: 64]);
    $display("[TB] block %s len=%0d last=%0d", tag, blk_length, blk_last);
    blk_ready = 1'b1;
    @(posedge clock);
    #1;
    blk_ready = 1'b0;
  endtask

  // Word w of a message whose byte i has value i.
  function automatic logic [63:0] ramp_word(input int wi);
    logic [63:0] d;
    for (int b = 0; b < 8; b++) d[8*b +: 8] = 8'(8*wi + b);
    return d;
  endfunction

  initial begin
    reset     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_bytes  = '0;
    blk_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_blk_valid", 64'(blk_valid), 64'd0);
    check("rst_blk_len", 64'(blk_length), 64'd0);
    check("rst_blk_last", 64'(blk_last), 64'd0);
    check("rst_blk_w0", blk_data[63:0], 64'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rel_in_ready_pre", 64'(in_ready), 64'd0);
    @(negedge clock);
    check("rel_in_ready_post", 64'(in_ready), 64'd1);

    // Empty message
    send_word(64'h0, 1'b1, 4'd0);
    exp_blk = '0;
    exp_blk[7:0] = 8'h1F;
    exp_blk[1087:1080] = 8'h80;
    recv_block("empty", exp_blk, 11'd0, 1'b1, 0);

    // "abc"
    send_word(64'h636261, 1'b1, 4'd3);
    exp_blk = '0;
    exp_blk[31:0] = 32'h1F636261;
    exp_blk[1087:1080] = 8'h80;
    recv_block("abc", exp_blk, 11'd24, 1'b1, 0);

    // "abc" with junk in the unused bytes must be masked off
    send_word(64'hDEADBEEF_AA636261, 1'b1, 4'd3);
    recv_block("abc_junk", exp_blk, 11'd24, 1'b1, 0);

    // in_bytes > 8 behaves as 8: byte 8 gets the pad
    send_word(64'h0807060504030201, 1'b1, 4'd15);
    exp_blk = '0;
    exp_blk[63:0] = 64'h0807060504030201;
    exp_blk[71:64] = 8'h1F;
    exp_blk[1087:1080] = 8'h80;
    recv_block("nb15", exp_blk, 11'd64, 1'b1, 0);

    // Full word then empty last word: pad at byte 8
    send_word(64'h1122334455667788, 1'b0, 4'd0);
    send_word(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
    exp_blk = '0;
    exp_blk[63:0] = 64'h1122334455667788;
    exp_blk[71:64] = 8'h1F;
    exp_blk[1087:1080] = 8'h80;
    recv_block("w1_b0", exp_blk, 11'd64, 1'b1, 0);

    // 135-byte message: pad and final bit share byte 135
    for (int k = 0; k < 16; k++) send_word(ramp_word(k), 1'b0, 4'd0);
    w = ramp_word(16);
    w[63:56] = 8'hAA;
    send_word(w, 1'b1, 4'd7);
    exp_blk = '0;
    for (int i = 0; i < 135; i++) exp_blk[8*i +: 8] = 8'(i);
    exp_blk[1087:1080] = 8'h9F;
    recv_block("m135", exp_blk, 11'd1080, 1'b1, 0);

    // 136-byte message: full block then pad-only block one cycle later
    for (int k = 0; k < 16; k++) send_word(ramp_word(k), 1'b0, 4'd0);
    send_word(ramp_word(16), 1'b1, 4'd8);
    exp_blk = '0;
    for (int i = 0; i < 136; i++) exp_blk[8*i +: 8] = 8'(i);
    recv_block("m136_a", exp_blk, 11'd1088, 1'b0, 0);
    exp_blk = '0;
    exp_blk[7:0] = 8'h1F;
    exp_blk[1087:1080] = 8'h80;
    recv_block("m136_b", exp_blk, 11'd0, 1'b1, 1);

    // Non-last 17-word run closes a block with length 1088, last=0
    for (int k = 0; k < 17; k++) send_word(ramp_word(k), 1'b0, 4'd0);
    exp_blk = '0;
    for (int i = 0; i < 136; i++) exp_blk[8*i +: 8] = 8'(i);
    recv_block("full_nl", exp_blk, 11'd1088, 1'b0, 0);
    send_word(64'h636261, 1'b1, 4'd3);
    exp_blk = '0;
    exp_blk[31:0] = 32'h1F636261;
    exp_blk[1087:1080] = 8'h80;
    recv_block("after_full", exp_blk, 11'd24, 1'b1, 0);

    // Back-pressure: 5 cycles of blk_ready low with stray in_valid
    send_word(64'h636261, 1'b1, 4'd3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check($sformatf("bp_valid_%0d", c), 64'(blk_valid), 64'd1);
      check($sformatf("bp_in_ready_%0d", c), 64'(in_ready), 64'd0);
      check($sformatf("bp_w0_%0d", c), blk_data[63:0], 64'h1F636261);
      in_valid = (c < 4);
      in_last  = 1'b1;
      in_bytes = 4'd8;
      in_data  = 64'hFFFF_0000_FFFF_0000;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    in_bytes = '0;
    recv_block("bp", exp_blk, 11'd24, 1'b1, 0);
    @(negedge clock);
    check("bp_in_ready_after", 64'(in_ready), 64'd1);
    check("bp_valid_after", 64'(blk_valid), 64'd0);

    // Reset after 5 accepted words discards the partial message
    for (int k = 0; k < 5; k++) send_word(ramp_word(k), 1'b0, 4'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check("mid_rst_valid", 64'(blk_valid), 64'd0);
    check("mid_rst_len", 64'(blk_length), 64'd0);
    check("mid_rst_last", 64'(blk_last), 64'd0);
    check("mid_rst_w0", blk_data[63:0], 64'd0);
    check("mid_rst_w4", blk_data[319:256], 64'd0);
    @(negedge clock);
    reset = 1'b1;
    send_word(64'h636261, 1'b1, 4'd3);
    recv_block("rst_abc", exp_blk, 11'd24, 1'b1, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
